// File: rtl/vga_text_pixel_source.sv
// Apple II 40x24 text-page pixel source: prefetches one cell ahead from VRAM/font ROM, two-clock pixel latency.
// Optional TEXT_FLASH_EN adds the frame flash counter so attribute code 01 blinks.
module vga_text_pixel_source #(
    parameter logic [9:0]  H_OFFSET     = 10'd40,
    parameter logic [9:0]  V_OFFSET     = 10'd48,
    parameter logic [15:0] FG_COLOR     = 16'h07E0,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter logic [15:0] BORDER_COLOR = 16'h0000
`ifdef TEXT_FLASH_EN
    ,
    parameter int          FLASH_FRAMES = 16
`endif
) (
    input  logic        clkVGA,
    input  logic        rst_n,
    input  logic [9:0]  xPosAhead,
    input  logic [9:0]  yPos,
    output logic [9:0]  vramAddr,
    input  logic [7:0]  vramData,
    output logic [8:0]  fontAddr,
    input  logic [7:0]  fontData,
    output logic [15:0] pixelOutput
);

    localparam logic [9:0] X_END    = H_OFFSET + 10'd560;
    localparam logic [9:0] Y_END    = V_OFFSET + 10'd384;
    localparam logic [9:0] FETCH_X0 = H_OFFSET - 10'd4;

    logic       req_valid, h_win, v_win;
    logic [9:0] y_seen;
    logic [4:0] row_reg, row_now;
    logic [3:0] lsub_reg, lsub_now;
    logic [9:0] fetch_x;
    logic [5:0] fcol;
    logic       line_start, trig, load;
    logic [3:0] trig_d;
    logic [9:0] cell_addr;
    logic [2:0] grow_p1;
    logic       attr_inv, inv_p2;
    logic [7:0] next_glyph, cur_glyph, glyph_use;
    logic       next_inv, cur_inv, inv_use;
    logic [3:0] sub_cnt, sub_now;
    logic       lit;
    logic       s1_valid, s1_win, s1_lit;
    logic [15:0] pix_next;

    assign req_valid = (xPosAhead < 10'd640) && (yPos < 10'd480);
    assign h_win     = (xPosAhead >= H_OFFSET) && (xPosAhead < X_END);
    assign v_win     = (yPos >= V_OFFSET) && (yPos < Y_END);

    // Line/row counters advance only when the request moves to the line right after the last valid one.
    always_comb begin
        row_now  = row_reg;
        lsub_now = lsub_reg;
        if (yPos == V_OFFSET) begin
            row_now  = '0;
            lsub_now = '0;
        end else if ((yPos < 10'd480) && (yPos == y_seen + 10'd1)) begin
            lsub_now = lsub_reg + 4'd1;
            if (lsub_reg == 4'd15) row_now = row_reg + 5'd1;
        end
    end

    assign line_start = (xPosAhead < FETCH_X0) || (xPosAhead >= 10'd640);
    assign trig       = v_win && !line_start && (xPosAhead == fetch_x) &&
                        (fcol < 6'd40) && (xPosAhead != 10'd639);
    assign load       = trig_d[3];
    assign cell_addr  = {row_now[2:0], 7'd0} + 10'(row_now[4:3]) * 10'd40 + 10'(fcol);

`ifdef TEXT_FLASH_EN
    logic [15:0] flash_cnt;
    logic        flash_phase;

    always_ff @(posedge clkVGA) begin
        if (!rst_n) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if ((xPosAhead == 10'd0) && (yPos == 10'd0)) begin
            if (flash_cnt == 16'(FLASH_FRAMES - 1)) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + 16'd1;
            end
        end
    end

    // Phase only moves at frame start, so resolving it at fetch time equals resolving it at display time.
    assign attr_inv = (vramData[7:6] == 2'b00) || ((vramData[7:6] == 2'b01) && flash_phase);
`else
    assign attr_inv = (vramData[7:6] == 2'b00);
`endif

    // The glyph being loaded this cycle is already needed for its first pixel.
    always_comb begin
        glyph_use = load ? next_glyph : cur_glyph;
        inv_use   = load ? next_inv : cur_inv;
        sub_now   = load ? 4'd0 : sub_cnt;
        lit       = glyph_use[sub_now[3:1]] ^ inv_use;
    end

    always_comb begin
        pix_next = 16'd0;
        if (s1_win)        pix_next = s1_lit ? FG_COLOR : BG_COLOR;
        else if (s1_valid) pix_next = BORDER_COLOR;
    end

    always_ff @(posedge clkVGA) begin
        if (!rst_n) begin
            y_seen      <= '0;
            row_reg     <= '0;
            lsub_reg    <= '0;
            fetch_x     <= '0;
            fcol        <= '0;
            trig_d      <= '0;
            vramAddr    <= '0;
            grow_p1     <= '0;
            fontAddr    <= '0;
            inv_p2      <= 1'b0;
            next_glyph  <= '0;
            next_inv    <= 1'b0;
            cur_glyph   <= '0;
            cur_inv     <= 1'b0;
            sub_cnt     <= '0;
            s1_valid    <= 1'b0;
            s1_win      <= 1'b0;
            s1_lit      <= 1'b0;
            pixelOutput <= '0;
        end else begin
            row_reg  <= row_now;
            lsub_reg <= lsub_now;
            if (yPos < 10'd480) y_seen <= yPos;

            if (line_start) begin
                fetch_x <= FETCH_X0;
                fcol    <= '0;
            end else if (trig) begin
                fetch_x <= fetch_x + 10'd14;
                fcol    <= fcol + 6'd1;
            end
            trig_d <= {trig_d[2:0], trig};

            if (trig) begin
                vramAddr <= cell_addr;
                grow_p1  <= lsub_now[3:1];
            end
            if (trig_d[0]) begin
                fontAddr <= {vramData[5:0], grow_p1};
                inv_p2   <= attr_inv;
            end
            if (trig_d[1]) begin
                next_glyph <= fontData;
                next_inv   <= inv_p2;
            end
            if (load) begin
                cur_glyph <= next_glyph;
                cur_inv   <= next_inv;
            end
            sub_cnt <= sub_now + 4'd1;

            s1_valid    <= req_valid;
            s1_win      <= req_valid && h_win && v_win;
            s1_lit      <= lit;
            pixelOutput <= pix_next;
        end
    end

endmodule

// File: tb/tb_vga_text_pixel_source.sv
// Bench for vga_text_pixel_source: raster-scan stimulus against an arithmetic model of the text page.
module tb_vga_text_pixel_source;

    localparam logic [15:0] FG     = 16'h07E0;
    localparam logic [15:0] BG     = 16'h0000;
    localparam logic [15:0] BORDER = 16'hF800;
    localparam int          FLASH  = 16;

    logic        clkVGA = 1'b0;
    logic        rst_n;
    logic [9:0]  xPosAhead, yPos;
    logic [9:0]  vramAddr;
    logic [7:0]  vramData;
    logic [8:0]  fontAddr;
    logic [7:0]  fontData;
    logic [15:0] pixelOutput;

    logic [7:0]  vram [1024];
    logic [7:0]  font [512];

    int total, bad, frame_idx;
    logic [15:0] hist_pix [2];
    bit          hist_ok  [2];
    int          hist_x   [2];
    int          hist_y   [2];
    logic [15:0] exp_pix;
    bit          exp_ok;
    int          exp_x, exp_y;

    vga_text_pixel_source #(
        .BORDER_COLOR(BORDER)
    ) dut (
        .clkVGA      (clkVGA),
        .rst_n       (rst_n),
        .xPosAhead   (xPosAhead),
        .yPos        (yPos),
        .vramAddr    (vramAddr),
        .vramData    (vramData),
        .fontAddr    (fontAddr),
        .fontData    (fontData),
        .pixelOutput (pixelOutput)
    );

    always #5 clkVGA = ~clkVGA;

    // Synchronous 1-clock memories.
    always @(posedge clkVGA) begin
        #1;
        vramData = vram[vramAddr];
        fontData = font[fontAddr];
    end

    function automatic bit model_phase(input int f);
`ifdef TEXT_FLASH_EN
        return ((f / FLASH) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] model_pix(input int x, input int y, input bit ph);
        int ax, ay, row, col, gr, gb;
        logic [7:0] code, g;
        bit inv;
        if (x >= 640 || y >= 480) return 16'd0;
        ax = x - 40;
        ay = y - 48;
        if (ax < 0 || ax >= 560 || ay < 0 || ay >= 384) return BORDER;
        row  = ay / 16;
        col  = ax / 14;
        gr   = (ay % 16) / 2;
        gb   = (ax % 14) / 2;
        code = vram[128 * (row % 8) + 40 * (row / 8) + col];
        g    = font[int'(code[5:0]) * 8 + gr];
        inv  = (code[7:6] == 2'b00) || ((code[7:6] == 2'b01) && ph);
        return (g[gb] ^ inv) ? FG : BG;
    endfunction

    // Advance one clock; exp_* then describe the pixel now visible on pixelOutput.
    task automatic tick(input int x, input int y);
        @(negedge clkVGA);
        exp_pix = hist_pix[1];
        exp_ok  = hist_ok[1];
        exp_x   = hist_x[1];
        exp_y   = hist_y[1];
        xPosAhead = 10'(x);
        yPos      = 10'(y);
        hist_pix[1] = hist_pix[0];
        hist_ok[1]  = hist_ok[0];
        hist_x[1]   = hist_x[0];
        hist_y[1]   = hist_y[0];
        hist_pix[0] = model_pix(x, y, model_phase(frame_idx));
        hist_ok[0]  = 1'b1;
        hist_x[0]   = x;
        hist_y[0]   = y;
        if (x == 0 && y == 0) frame_idx++;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clkVGA);
        rst_n = 1'b0;
        xPosAhead = 10'd100;
        yPos = 10'd100;
        repeat (cycles) @(negedge clkVGA);
        rst_n = 1'b1;
        hist_ok[0] = 1'b0;
        hist_ok[1] = 1'b0;
        frame_idx = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        xPosAhead = 10'd100;
        yPos = 10'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkVGA);
            total++;
            if (pixelOutput !== 16'd0) begin
                bad++;
                $display("FAIL reset_pixel cycle %0d: got %h want 0000", i, pixelOutput);
            end
            total++;
            if (vramAddr !== 10'd0) begin
                bad++;
                $display("FAIL reset_vram_addr cycle %0d: got %0d want 0", i, vramAddr);
            end
            total++;
            if (fontAddr !== 9'd0) begin
                bad++;
                $display("FAIL reset_font_addr cycle %0d: got %0d want 0", i, fontAddr);
            end
        end
        rst_n = 1'b1;
        hist_ok[0] = 1'b0;
        hist_ok[1] = 1'b0;
        frame_idx = 0;
    endtask

    task automatic test_addressing();
        int ty [3] = '{48, 176, 416};
        int tc [3] = '{0, 0, 39};
        int k, trig_x, ay, row, want_addr, want_font;
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        k = 0;
        for (int y = 48; y <= 416; y++) begin
            if (k < 3 && y == ty[k]) begin
                trig_x = 36 + 14 * tc[k];
                for (int x = 0; x <= trig_x + 2; x++) begin
                    tick(x, y);
                    ay = y - 48;
                    row = ay / 16;
                    want_addr = 128 * (row % 8) + 40 * (row / 8) + tc[k];
                    if (x == trig_x + 1) begin
                        total++;
                        if (vramAddr !== 10'(want_addr)) begin
                            bad++;
                            $display("FAIL addr_vram row=%0d col=%0d: got %0d want %0d", row, tc[k], vramAddr, want_addr);
                        end
                    end
                    if (x == trig_x + 2) begin
                        want_font = int'(vram[want_addr][5:0]) * 8 + (ay % 16) / 2;
                        total++;
                        if (fontAddr !== 9'(want_font)) begin
                            bad++;
                            $display("FAIL addr_font row=%0d col=%0d: got %0d want %0d", row, tc[k], fontAddr, want_font);
                        end
                    end
                end
                tick(800, y);
                k++;
            end else begin
                tick(800, y);
            end
        end
    endtask

    task automatic test_glyph(input logic [7:0] code);
        logic [15:0] w44, w46;
        for (int i = 0; i < 1024; i++) vram[i] = code;
        for (int i = 0; i < 512; i++) font[i] = 8'h08;
        w46 = (code[7:6] == 2'b00) ? BG : FG;
        w44 = (code[7:6] == 2'b00) ? FG : BG;
        tick(800, 47);
        for (int x = 0; x < 642; x++) begin
            tick((x < 640) ? x : 800, 48);
            if (exp_ok) begin
                total++;
                if (pixelOutput !== exp_pix) begin
                    bad++;
                    $display("FAIL glyph_model code=%h x=%0d y=%0d: got %h want %h", code, exp_x, exp_y, pixelOutput, exp_pix);
                end
                if (exp_y == 48 && (exp_x == 46 || exp_x == 47)) begin
                    total++;
                    if (pixelOutput !== w46) begin
                        bad++;
                        $display("FAIL glyph_lit code=%h x=%0d: got %h want %h", code, exp_x, pixelOutput, w46);
                    end
                end
                if (exp_y == 48 && exp_x == 44) begin
                    total++;
                    if (pixelOutput !== w44) begin
                        bad++;
                        $display("FAIL glyph_unlit code=%h x=44: got %h want %h", code, pixelOutput, w44);
                    end
                end
            end
        end
    endtask

    task automatic test_border_blank();
        int bx [7] = '{20, 800, 700, 100, 100, 639, 30};
        int by [7] = '{100, 100, 100, 500, 525, 479, 47};
        logic [15:0] bw [7] = '{16'hF800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF800, 16'hF800};
        for (int i = 0; i < 9; i++) begin
            tick((i < 7) ? bx[i] : 800, (i < 7) ? by[i] : 525);
            if (i >= 2) begin
                total++;
                if (pixelOutput !== bw[i - 2]) begin
                    bad++;
                    $display("FAIL border_blank x=%0d y=%0d: got %h want %h", bx[i - 2], by[i - 2], pixelOutput, bw[i - 2]);
                end
            end
        end
    endtask

    task automatic test_random_page();
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 512; i++) font[i] = 8'($urandom);
        for (int y = 40; y < 525; y++) begin
            if (y == 48 || y == 431 || y == 440 || $urandom_range(0, 31) == 0) begin
                for (int x = 0; x < 642; x++) begin
                    tick((x < 640) ? x : 800, y);
                    if (exp_ok) begin
                        total++;
                        if (pixelOutput !== exp_pix) begin
                            bad++;
                            $display("FAIL random_page x=%0d y=%0d: got %h want %h", exp_x, exp_y, pixelOutput, exp_pix);
                        end
                    end
                end
            end else begin
                tick(800, y);
            end
        end
    endtask

    task automatic test_flash();
        bit inv_frame;
        logic [15:0] want;
        apply_reset(2);
        for (int i = 0; i < 1024; i++) vram[i] = 8'h41;
        for (int i = 0; i < 512; i++) font[i] = 8'h08;
        for (int f = 0; f < 34; f++) begin
            if (f > 0) tick(0, 0);
`ifdef TEXT_FLASH_EN
            inv_frame = ((f / 16) % 2) == 1;
`else
            inv_frame = 1'b0;
`endif
            want = inv_frame ? BG : FG;
            for (int x = 0; x < 62; x++) begin
                tick((x < 60) ? x : 800, 48);
                if (exp_ok) begin
                    total++;
                    if (pixelOutput !== exp_pix) begin
                        bad++;
                        $display("FAIL flash_model frame=%0d x=%0d: got %h want %h", f, exp_x, pixelOutput, exp_pix);
                    end
                    if (exp_y == 48 && exp_x == 46) begin
                        total++;
                        if (pixelOutput !== want) begin
                            bad++;
                            $display("FAIL flash_phase frame=%0d: got %h want %h", f, pixelOutput, want);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        frame_idx = 0;
        rst_n = 1'b0;
        xPosAhead = 10'd100;
        yPos = 10'd100;
        hist_ok[0] = 1'b0;
        hist_ok[1] = 1'b0;
        for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
        for (int i = 0; i < 512; i++) font[i] = 8'h00;

        test_reset();
        test_addressing();
        test_glyph(8'hC1);
        test_glyph(8'h01);
        test_border_blank();
        test_random_page();
        test_flash();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
